// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative signed multiply / divide / modulo unit.
// A start request latches operand magnitudes and sign flags. CALC then runs
// one shift-add (mult) or restoring-division (div/mod) step per cycle for
// WIDTH cycles. FIX applies the result signs and loads the output registers.
// DONE holds the results and pulses done for one cycle.
// Handshake: inStart is accepted only in IDLE or DONE. outBusy is high in CALC
// and FIX, and any inStart seen while it is high is dropped. outDone is high
// only in the DONE cycle, so the two are never high together.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inStart,
  input  logic [3:0]       inAluOp,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] outResult,
  output logic [WIDTH-1:0] outHi,
  output logic             outBusy,
  output logic             outDone,
  output logic             outDivZero,
  output logic             outIllegal,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd8;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_prod;   // operand signs differ: negate product / quotient
  logic               neg_rem;    // dividend negative: negate remainder
  logic [CW-1:0]      cnt;
  // mult: {partial product high, remaining multiplier bits}
  // div : {partial remainder, dividend bits shifting out / quotient bits shifting in}
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   a_in_mag;
  logic [WIDTH-1:0]   b_in_mag;

  assign dbg_state = state;

  // Iteration step datapath, sign fix-up and input magnitudes
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : {WIDTH{1'b0}})};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_mag};
    // The difference is below b_mag whenever it is taken, so WIDTH bits suffice
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_mag) : div_shift[WIDTH-1:0];
    prod_s    = neg_prod ? -acc : acc;
    quo_s     = neg_prod ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_s     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // The most-negative value maps to 2^(WIDTH-1), which is exact as unsigned
    a_in_mag  = inA[WIDTH-1] ? -inA : inA;
    b_in_mag  = inB[WIDTH-1] ? -inB : inB;
  end

  // Control FSM with registered outputs
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state      <= IDLE;
      op         <= '0;
      a_mag      <= '0;
      b_mag      <= '0;
      neg_prod   <= 1'b0;
      neg_rem    <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      outResult  <= '0;
      outHi      <= '0;
      outBusy    <= 1'b0;
      outDone    <= 1'b0;
      outDivZero <= 1'b0;
      outIllegal <= 1'b0;
    end else begin
      outDone <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (inStart) begin
            op         <= inAluOp;
            a_mag      <= a_in_mag;
            b_mag      <= b_in_mag;
            neg_prod   <= inA[WIDTH-1] ^ inB[WIDTH-1];
            neg_rem    <= inA[WIDTH-1];
            cnt        <= '0;
            outDivZero <= 1'b0;
            outIllegal <= 1'b0;
            if (inAluOp == OP_MULT) begin
              acc     <= {{WIDTH{1'b0}}, b_in_mag};
              outBusy <= 1'b1;
              state   <= CALC;
            end else if (inAluOp == OP_DIV || inAluOp == OP_MOD) begin
              if (inB == '0) begin
                outDivZero <= 1'b1;
                outResult  <= '1;
                outHi      <= inA;
                outDone    <= 1'b1;
                state      <= DONE;
              end else begin
                acc     <= {{WIDTH{1'b0}}, a_in_mag};
                outBusy <= 1'b1;
                state   <= CALC;
              end
            end else begin
              outIllegal <= 1'b1;
              outResult  <= '0;
              outHi      <= '0;
              outDone    <= 1'b1;
              state      <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (op == OP_MULT) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {div_rem, acc[WIDTH-2:0], div_ge};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          case (op)
            OP_MULT: begin
              outResult <= prod_s[WIDTH-1:0];
              outHi     <= prod_s[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
              outResult <= quo_s;
              outHi     <= rem_s;
            end
            default: begin
              outResult <= rem_s;
              outHi     <= quo_s;
            end
          endcase
          outBusy <= 1'b0;
          outDone <= 1'b1;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq (WIDTH=32): directed scenarios plus a random
// stream checked against a plain-arithmetic reference model.
module tb_alu_muldiv_seq;

  localparam int W = 32;
  localparam int LAT_BUSY = W + 1;

  logic          inClk;
  logic          inRst;
  logic          inStart;
  logic [3:0]    inAluOp;
  logic [W-1:0]  inA;
  logic [W-1:0]  inB;
  logic [W-1:0]  outResult;
  logic [W-1:0]  outHi;
  logic          outBusy;
  logic          outDone;
  logic          outDivZero;
  logic          outIllegal;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_errors;

  // Expected {illegal, divzero, hi, result} per operation
  logic [2*W+1:0] exp_q[$];

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .inClk(inClk), .inRst(inRst), .inStart(inStart), .inAluOp(inAluOp),
    .inA(inA), .inB(inB), .outResult(outResult), .outHi(outHi),
    .outBusy(outBusy), .outDone(outDone), .outDivZero(outDivZero),
    .outIllegal(outIllegal), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    inClk = 1'b0;
    forever #5 inClk = ~inClk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: signed arithmetic on 64-bit integers
  function automatic logic [2*W+1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, p, q, m;
    logic [W-1:0] r, h;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd2) begin
      p = sa * sb;
      r = p[W-1:0];
      h = p[2*W-1:W];
      return {2'b00, h, r};
    end else if (op == 4'd3 || op == 4'd8) begin
      if (b == '0) return {2'b01, a, {W{1'b1}}};
      q = sa / sb;
      m = sa % sb;
      if (op == 4'd3) return {2'b00, m[W-1:0], q[W-1:0]};
      return {2'b00, q[W-1:0], m[W-1:0]};
    end
    return {2'b10, {W{1'b0}}, {W{1'b0}}};
  endfunction

  function automatic logic [2*W+1:0] observed();
    return {outIllegal, outDivZero, outHi, outResult};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge inClk);
    #1;
  endtask

  // Present a request for one edge, then scramble the inputs
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge inClk);
    inStart = 1'b1;
    inAluOp = op;
    inA     = a;
    inB     = b;
    step();
    inStart = 1'b0;
    inA     = $urandom;
    inB     = $urandom;
    inAluOp = 4'($urandom_range(0, 15));
  endtask

  // Wait (bounded) for outDone; counts busy cycles and flags busy/done overlap
  task automatic wait_done(output int busy_cnt, output int cycles, output bit ok);
    busy_cnt = 0;
    cycles   = 0;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if (outBusy && outDone) begin
        n_errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both", outBusy, outDone);
      end
      if (outDone) begin
        ok = 1'b1;
        break;
      end
      if (outBusy) busy_cnt++;
      cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    inRst = 1'b1; inStart = 1'b0; inAluOp = '0; inA = '0; inB = '0;
    repeat (3) step();
    n_checks++;
    if ({outBusy, outDone, observed()} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h required 0", {outBusy, outDone, observed()});
    end
    inRst = 1'b0;
    step();
  endtask

  task automatic test_mult_div();
    logic [3:0]     t_op[5];
    logic [W-1:0]   t_a[5];
    logic [W-1:0]   t_b[5];
    logic [2*W+1:0] t_exp[5];
    int busy, cyc;
    bit ok;
    t_op  = '{4'd2, 4'd3, 4'd8, 4'd3, 4'd2};
    t_a   = '{32'd7, -32'sd17, -32'sd17, 32'h8000_0000, 32'h8000_0000};
    t_b   = '{-32'sd3, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
    t_exp = '{{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
              {2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD},
              {2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFE},
              {2'b00, 32'h0000_0000, 32'h8000_0000},
              {2'b00, 32'h4000_0000, 32'h0000_0000}};
    for (int i = 0; i < 5; i++) begin
      start_op(t_op[i], t_a[i], t_b[i]);
      wait_done(busy, cyc, ok);
      n_checks++;
      if (!ok || busy != LAT_BUSY) begin
        n_errors++;
        $display("FAIL op%0d_timing: done=%0b busy_cycles=%0d required done=1 busy_cycles=%0d",
                 i, ok, busy, LAT_BUSY);
      end
      n_checks++;
      if (observed() !== t_exp[i]) begin
        n_errors++;
        $display("FAIL op%0d_result: got %h required %h", i, observed(), t_exp[i]);
      end
      step();
      n_checks++;
      if ({outDone, outBusy, observed()} !== {2'b00, t_exp[i]}) begin
        n_errors++;
        $display("FAIL op%0d_hold: got %h required %h", i, {outDone, outBusy, observed()},
                 {2'b00, t_exp[i]});
      end
    end
  endtask

  task automatic test_zero_illegal();
    logic [3:0]     t_op[3];
    logic [W-1:0]   t_a[3];
    logic [W-1:0]   t_b[3];
    logic [2*W+1:0] t_exp[3];
    int busy, cyc;
    bit ok;
    t_op  = '{4'd3, 4'd8, 4'd5};
    t_a   = '{32'd9, -32'sd5, 32'd11};
    t_b   = '{32'd0, 32'd0, 32'd3};
    t_exp = '{{2'b01, 32'd9, 32'hFFFF_FFFF},
              {2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFF},
              {2'b10, 32'd0, 32'd0}};
    for (int i = 0; i < 3; i++) begin
      start_op(t_op[i], t_a[i], t_b[i]);
      wait_done(busy, cyc, ok);
      n_checks++;
      if (!ok || cyc != 0 || busy != 0) begin
        n_errors++;
        $display("FAIL fast%0d_timing: done=%0b wait=%0d busy=%0d required done=1 wait=0 busy=0",
                 i, ok, cyc, busy);
      end
      n_checks++;
      if (observed() !== t_exp[i]) begin
        n_errors++;
        $display("FAIL fast%0d_result: got %h required %h", i, observed(), t_exp[i]);
      end
      step();
      n_checks++;
      if (outDone !== 1'b0) begin
        n_errors++;
        $display("FAIL fast%0d_single_pulse: done=%0b required 0", i, outDone);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int busy, rest, cyc;
    bit ok;
    start_op(4'd2, 32'd3, 32'd4);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (outBusy) busy++;
      step();
    end
    if (outBusy) busy++;
    inStart = 1'b1; inAluOp = 4'd3; inA = 32'd10; inB = 32'd2;
    step();
    inStart = 1'b0;
    wait_done(rest, cyc, ok);
    n_checks++;
    if (!ok || busy + rest != LAT_BUSY) begin
      n_errors++;
      $display("FAIL busy_drop_timing: done=%0b busy_cycles=%0d required done=1 busy_cycles=%0d",
               ok, busy + rest, LAT_BUSY);
    end
    n_checks++;
    if (observed() !== {2'b00, 32'd0, 32'd12}) begin
      n_errors++;
      $display("FAIL busy_drop_result: got %h required %h", observed(), {2'b00, 32'd0, 32'd12});
    end
    step();
    n_checks++;
    if ({outDone, outBusy} !== 2'b00) begin
      n_errors++;
      $display("FAIL busy_drop_not_queued: done/busy=%b required 00", {outDone, outBusy});
    end
  endtask

  task automatic test_back_to_back();
    int busy, cyc;
    bit ok;
    start_op(4'd2, 32'd6, 32'd7);
    wait_done(busy, cyc, ok);
    n_checks++;
    if (!ok || observed() !== {2'b00, 32'd0, 32'd42}) begin
      n_errors++;
      $display("FAIL b2b_first: done=%0b got %h required %h", ok, observed(),
               {2'b00, 32'd0, 32'd42});
    end
    inStart = 1'b1; inAluOp = 4'd3; inA = 32'd10; inB = 32'd2;
    step();
    inStart = 1'b0; inA = $urandom; inB = $urandom;
    wait_done(busy, cyc, ok);
    n_checks++;
    if (!ok || busy != LAT_BUSY || cyc != LAT_BUSY) begin
      n_errors++;
      $display("FAIL b2b_timing: done=%0b busy=%0d wait=%0d required done=1 busy=%0d wait=%0d",
               ok, busy, cyc, LAT_BUSY, LAT_BUSY);
    end
    n_checks++;
    if (observed() !== {2'b00, 32'd0, 32'd5}) begin
      n_errors++;
      $display("FAIL b2b_result: got %h required %h", observed(), {2'b00, 32'd0, 32'd5});
    end
    step();
  endtask

  task automatic test_reset_mid_calc();
    int busy, cyc;
    bit ok, seen;
    start_op(4'd2, 32'd5, 32'd7);
    repeat (14) step();
    inRst = 1'b1;
    step();
    inRst = 1'b0;
    n_checks++;
    if ({outBusy, outDone, observed()} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got %h required 0", {outBusy, outDone, observed()});
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (outDone || outBusy) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL midreset_abandon: activity_seen=%0b required 0", seen);
    end
    start_op(4'd2, 32'd2, 32'd2);
    wait_done(busy, cyc, ok);
    n_checks++;
    if (!ok || busy != LAT_BUSY || observed() !== {2'b00, 32'd0, 32'd4}) begin
      n_errors++;
      $display("FAIL midreset_recover: done=%0b busy=%0d got %h required %h", ok, busy,
               observed(), {2'b00, 32'd0, 32'd4});
    end
    step();
  endtask

  task automatic test_random();
    logic [3:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W+1:0] exp;
    int busy, cyc, exp_busy, sel;
    bit ok;
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) op = 4'd2;
      else if (sel < 6) op = 4'd3;
      else if (sel < 9) op = 4'd8;
      else op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($signed($urandom_range(0, 20)) - 10);
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      exp = model(op, a, b);
      exp_q.push_back(exp);
      exp_busy = (exp[2*W+1:2*W] == 2'b00) ? LAT_BUSY : 0;
      start_op(op, a, b);
      wait_done(busy, cyc, ok);
      n_checks++;
      if (!ok || busy != exp_busy) begin
        n_errors++;
        $display("FAIL rnd%0d_timing: done=%0b busy=%0d required done=1 busy=%0d",
                 i, ok, busy, exp_busy);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (observed() !== exp) begin
        n_errors++;
        $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h required %h",
                 i, op, a, b, observed(), exp);
      end
      if ($urandom_range(0, 1) == 0) step();
    end
  endtask

  // Test sequence and final report
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_mult_div();
    test_zero_illegal();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
